rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Arbitrates the register file's single write port (A3/WD3/Reg_Write_En, written on falling clk edge) between two requesters. The pipeline writeback stage is requester 0: it cannot stall and always wins. Requester 1 is a long-latency unit (mul/div or load miss path); its results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter raises a stall request so the pipeline inserts a bubble, and busy flags let hazard logic see pending writes.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive un-drained cycles of a non-empty FIFO before stall_req asserts (>=1)
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wb_we  in  1  writeback stage write enable
wb_rd  in  AW  writeback destination register
wb_data  in  DW  writeback data
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept (= not full)
lu_rd  in  AW  long-latency destination register
lu_data  in  DW  long-latency result
rf_we  out  1  to register file Reg_Write_En
rf_a3  out  AW  to register file A3
rf_wd3  out  DW  to register file WD3
stall_req  out  1  registered request to hazard unit to bubble the writeback stage
q1_addr  in  AW  hazard query address 1 (decode rs1)
q2_addr  in  AW  hazard query address 2 (decode rs2)
q1_busy  out  1  q1_addr matches a pending FIFO entry
q2_busy  out  1  q2_addr matches a pending FIFO entry
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low): FIFO empty, pointers 0, age counter 0, stall_req=0, fifo_count=0, lu_ready=0, rf_we=0. q1_busy and q2_busy read 0 because the FIFO is empty.
- After reset deassert: lu_ready = (fifo_count != DEPTH), combinational.
- Write-port selection, combinational, same cycle:
  - wb_sel = wb_we && wb_rd != 0.
  - If wb_sel: rf_we=1, rf_a3=wb_rd, rf_wd3=wb_data.
  - Else if FIFO non-empty: rf_we=1, rf_a3/rf_wd3 = head entry; pop at the rising edge.
  - Else: rf_we=0. rf_a3/rf_wd3 are don't-care but must hold the head or the WB value, never X when the FIFO is empty.
- wb_we with wb_rd=0 is not a write. The port is free that cycle and the FIFO may drain.
- Push: lu_valid && lu_ready at the rising edge.
  - lu_rd != 0: store {lu_rd, lu_data} at the tail.
  - lu_rd = 0: handshake completes, but nothing is stored.
- No bypass: a pushed entry is written to the register file at the earliest on the next cycle (minimum latency 1 cycle).
- Push and pop in the same cycle: both take effect. Occupancy is unchanged, pointers wrap modulo DEPTH.
- Full: lu_ready=0. A pop while full frees a slot; lu_ready rises in the following cycle, since it is derived from registered occupancy.
- FIFO order is strict; entries drain oldest first.
- Age counter:
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
- stall_req (registered):
  - Sets on the edge where the age counter reaches STARVE_LIMIT.
  - Clears on the edge after the first pop.
- While stall_req=1, the pipeline bubbles, so wb_sel=0 and the head drains. If wb_sel is still 1, WB still wins, the counter stays saturated and stall_req stays high.
- Hazard flags: qN_busy = (qN_addr != 0) && any valid entry has rd == qN_addr. This is combinational over valid entries only. The head entry being written this cycle still counts as busy; the register file write lands on the falling edge.
- Write-after-write safety (a WB write to an rd that is pending in the FIFO) is the issue logic's duty, using the busy flags. The arbiter does not reorder.
- Reset mid-operation: all pending entries are discarded immediately and rf_we drops asynchronously.

Optional Feature:
Macro RF_WARB_FWD_EN.
- Defined: adds outputs q1_data and q2_data (DW each). Each carries the data of the youngest valid FIFO entry whose rd matches qN_addr, or 0 on no match. Decode can then forward pending long-latency results instead of stalling.
- Undefined: these ports do not exist; only the busy flags are provided.

Test Plan:
- Reset, then idle with no requests: rf_we=0, lu_ready=1, fifo_count=0, stall_req=0.
- Push rd=5 data=0xDEAD with wb_we=0. Expected: fifo_count=1 next cycle, and the cycle after shows rf_we=1, rf_a3=5, rf_wd3=0xDEAD, then fifo_count=0. q1_addr=5 reads busy=1 until that pop.
- Push rd=0 data=0x1234: handshake accepted, fifo_count stays 0, rf_we never asserts.
- Fill 4 entries (rd=1..4) while wb_we=1, wb_rd=7 every cycle. Expected:
  - lu_ready=0 at count 4.
  - rf_a3=7 every cycle.
  - stall_req rises after 8 un-drained cycles.
  - Drop wb_we: entries drain in order 1,2,3,4 on consecutive cycles, and stall_req clears after the first pop.
- Simultaneous push (rd=9) and pop of head rd=3 at count 2: count stays 2, next write is the remaining older entry, then rd=9.
- Assert rst_n=0 with 3 entries pending: rf_we drops immediately. After release, count=0 and no stale writes occur. With RF_WARB_FWD_EN, push rd=6 0xA then rd=6 0xB: q1_addr=6 returns 0xB.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter with long-latency result FIFO
// Optional forwarding outputs q1_data/q2_data are enabled by RF_WARB_FWD_EN.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DW           = 32,
    parameter int AW           = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_we,
    input  logic [AW-1:0]          wb_rd,
    input  logic [DW-1:0]          wb_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [AW-1:0]          lu_rd,
    input  logic [DW-1:0]          lu_data,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_a3,
    output logic [DW-1:0]          rf_wd3,
    output logic                   stall_req,
    input  logic [AW-1:0]          q1_addr,
    input  logic [AW-1:0]          q2_addr,
    output logic                   q1_busy,
    output logic                   q2_busy,
`ifdef RF_WARB_FWD_EN
    output logic [DW-1:0]          q1_data,
    output logic [DW-1:0]          q2_data,
`endif
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int AGW = $clog2(STARVE_LIMIT + 1);

    logic [AW-1:0]  mem_rd   [DEPTH];
    logic [DW-1:0]  mem_data [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr, idx;
    logic [CW-1:0]  count;
    logic [AGW-1:0] age, age_next;
    logic           empty, full, wb_sel, pop, store;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign wb_sel     = wb_we && (wb_rd != '0);
    assign pop        = !wb_sel && !empty;
    assign lu_ready   = rst_n && !full;
    assign store      = lu_valid && lu_ready && (lu_rd != '0);
    assign fifo_count = count;

    // rf_we is gated by rst_n so a reset kills the write port without waiting for a clock
    assign rf_we  = rst_n && (wb_sel || !empty);
    assign rf_a3  = (wb_sel || empty) ? wb_rd   : mem_rd[rd_ptr];
    assign rf_wd3 = (wb_sel || empty) ? wb_data : mem_data[rd_ptr];

    always_comb begin
        age_next = age;
        if (empty || pop)
            age_next = '0;
        else if (age != AGW'(STARVE_LIMIT))
            age_next = age + AGW'(1);
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_rd[wr_ptr]   <= lu_rd;
            mem_data[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            age       <= '0;
            stall_req <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count     <= count + CW'(store) - CW'(pop);
            age       <= age_next;
            stall_req <= (age_next == AGW'(STARVE_LIMIT));
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest entry
    always_comb begin
        q1_busy = 1'b0;
        q2_busy = 1'b0;
        idx     = '0;
`ifdef RF_WARB_FWD_EN
        q1_data = '0;
        q2_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if ((q1_addr != '0) && (mem_rd[idx] == q1_addr)) begin
                    q1_busy = 1'b1;
`ifdef RF_WARB_FWD_EN
                    q1_data = mem_data[idx];
`endif
                end
                if ((q2_addr != '0) && (mem_rd[idx] == q2_addr)) begin
                    q2_busy = 1'b1;
`ifdef RF_WARB_FWD_EN
                    q2_data = mem_data[idx];
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter
// Forwarding outputs are exercised when RF_WARB_FWD_EN is defined.
module tb_rf_write_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_we, lu_valid, lu_ready, rf_we, stall_req, q1_busy, q2_busy;
    logic [AW-1:0] wb_rd, lu_rd, rf_a3, q1_addr, q2_addr;
    logic [DW-1:0] wb_data, lu_data, rf_wd3;
    logic [2:0]    fifo_count;
`ifdef RF_WARB_FWD_EN
    logic [DW-1:0] q1_data, q2_data;
`endif

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .stall_req(stall_req),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
`ifdef RF_WARB_FWD_EN
        .q1_data(q1_data), .q2_data(q2_data),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   streak;
    bit   mstall;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit busy_of(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] fwd_of(input logic [AW-1:0] a);
        logic [DW-1:0] r = '0;
        if (a != 0) foreach (mq[i]) if (mq[i].rd == a) r = mq[i].data;
        return r;
    endfunction

    // One cycle: drive after the edge, check mid-cycle, then advance the model across the edge
    task automatic step(input logic we, input logic [AW-1:0] wrd, input logic [DW-1:0] wd,
                        input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bit sel, did_pop, took;
        int sz;
        wb_we = we; wb_rd = wrd; wb_data = wd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        q1_addr = a1; q2_addr = a2;
        @(negedge clk);
        sz  = mq.size();
        sel = we && (wrd != 0);
        check("lu_ready", lu_ready, sz != DEPTH);
        check("fifo_count", fifo_count, sz);
        check("stall_req", stall_req, mstall);
        check("rf_we", rf_we, sel || sz > 0);
        if (sel) begin
            check("rf_a3_wb", rf_a3, wrd);
            check("rf_wd3_wb", rf_wd3, wd);
        end else if (sz > 0) begin
            check("rf_a3_q", rf_a3, mq[0].rd);
            check("rf_wd3_q", rf_wd3, mq[0].data);
        end
        check("q1_busy", q1_busy, busy_of(a1));
        check("q2_busy", q2_busy, busy_of(a2));
`ifdef RF_WARB_FWD_EN
        check("q1_data", q1_data, fwd_of(a1));
        check("q2_data", q2_data, fwd_of(a2));
`endif
        did_pop = !sel && sz > 0;
        took    = lv && sz != DEPTH;
        if (did_pop) void'(mq.pop_front());
        if (took && lrd != 0) mq.push_back('{rd: lrd, data: ld});
        if (sz == 0 || did_pop) streak = 0;
        else if (streak < LIMIT) streak++;
        mstall = (streak == LIMIT);
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd7; lu_valid = 1'b1; lu_rd = 5'd3;
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", lu_ready, 1'b0);
        check("rst_stall", stall_req, 1'b0);
        q1_addr = 5'd1;
        #1;
        check("rst_busy", q1_busy, 1'b0);
        @(posedge clk);
        #1;
        check("rst_count_hold", fifo_count, 0);
        mq.delete();
        streak = 0;
        mstall = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        int ph;
        logic we;
        logic [AW-1:0] wr;
        rst_n = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        q1_addr = 5'd5; q2_addr = '0;
        streak = 0; mstall = 1'b0;
        #1;
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_ready", lu_ready, 1'b0);
        check("reset_count", fifo_count, 0);
        check("reset_stall", stall_req, 1'b0);
        check("reset_busy", q1_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        // single push, then drain
        step(0, 0, 0, 1, 5, 32'hDEAD, 5, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 5, 0);
        // rd=0 push is swallowed; wb_rd=0 is not a write
        step(1, 0, 32'h55, 1, 0, 32'h1234, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
        // fill while writeback owns the port, let starvation build, then drain
        for (int k = 0; k < 12; k++)
            step(1, 7, 32'h700 + k, k < 5, AW'(k + 1), 32'h100 + k, AW'(k % 5), 5'd3);
        for (int k = 0; k < 6; k++)
            step(0, 0, 0, 0, 0, 0, AW'(k + 1), 5'd4);
        // simultaneous push and pop at count 2
        step(1, 7, 1, 1, 3, 32'h33, 0, 0);
        step(1, 7, 2, 1, 4, 32'h44, 0, 0);
        step(0, 0, 0, 1, 9, 32'h99, 9, 3);
        repeat (3) step(0, 0, 0, 0, 0, 0, 9, 4);
        // youngest match for forwarding
        step(1, 8, 0, 1, 6, 32'hA, 6, 0);
        step(1, 8, 0, 1, 6, 32'hB, 6, 0);
        step(1, 8, 0, 0, 0, 0, 6, 6);
        // reset with pending entries
        step(1, 7, 0, 1, 1, 32'h11, 0, 0);
        mid_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 2);

        for (int i = 0; i < 600; i++) begin
            ph = (i / 60) % 3;
            case (ph)
                0: begin we = ($urandom_range(0, 9) < 2); wr = AW'($urandom_range(0, 7)); end
                1: begin we = ($urandom_range(0, 19) != 0); wr = AW'($urandom_range(1, 31)); end
                default: begin we = $urandom_range(0, 1); wr = AW'($urandom_range(0, 7)); end
            endcase
            step(we, wr, $urandom, ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)),
                 $urandom, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            if (i == 300) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
